fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage. Holds the architectural PC and issues in-order fetch requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents {instr, pc} to decode/branching with a valid/ready handshake.
- Accepts the redirect target produced by the branching stage and discards all wrong-path fetches, both in flight and buffered.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM states, instruction size and the buffered entry.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   localparam int INSTR_BYTES  = 4;
   localparam int FETCH_ADDR_W = 32;
   localparam int FETCH_DATA_W = 32;

   typedef struct packed {
      logic [FETCH_DATA_W-1:0] instr;
      logic [FETCH_ADDR_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush; used for both the output buffer and the in-flight PC queue.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Flush overrides any push or pop in the same cycle.
   always_comb begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
      if (flush) begin
         do_push_s = 1'b0;
         do_pop_s  = 1'b0;
      end else begin
         do_push_s = push && (count_r != DEPTH_C);
         do_pop_s  = pop && (count_r != '0);
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;
   assign empty = (count_r == '0);
   assign full  = (count_r == DEPTH_C);

endmodule

// File: rtl/fetch_unit.sv
// PC and instruction-fetch stage with redirect flushing.
// Optional misaligned-redirect fault/halt when FETCH_ALIGN_CHECK_EN is defined.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic              fault
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0]       DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

   fetch_state_t      state_r;
   fetch_state_t      state_next_s;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] target_s;
   logic [CW-1:0]     outstanding_r;
   logic [CW-1:0]     outstanding_next_s;
   logic [CW-1:0]     drop_cnt_r;
   logic              fault_r;
   logic              aligned_s;
   logic              fault_hit_s;
   logic              redirect_ok_s;
   logic              credit_s;
   logic              req_valid_s;
   logic              req_fire_s;
   logic              rsp_keep_s;
   logic              out_fire_s;

   logic [ADDR_W-1:0]        pq_head_s;
   logic [CW-1:0]            pq_count_s;
   logic                     pq_empty_s;
   logic                     pq_full_s;
   logic [DATA_W+ADDR_W-1:0] of_head_s;
   logic [CW-1:0]            of_count_s;
   logic                     of_empty_s;
   logic                     of_full_s;
   logic                     unused_ok_s;

`ifdef FETCH_ALIGN_CHECK_EN
   assign aligned_s = (redirect_pc[1:0] == 2'b00);
`else
   assign aligned_s = 1'b1;
`endif

   // A halted unit ignores redirects; a misaligned one faults instead of redirecting.
   assign fault_hit_s   = redirect_valid && (state_r != HALT) && !aligned_s;
   assign redirect_ok_s = redirect_valid && (state_r != HALT) && aligned_s;
   assign target_s      = {redirect_pc[ADDR_W-1:2], 2'b00};

   assign credit_s    = (({1'b0, outstanding_r} + {1'b0, of_count_s}) < DEPTH_C);
   assign req_valid_s = (state_r == FETCH) && credit_s && !fault_hit_s;
   assign req_fire_s  = req_valid_s && imem_req_ready;
   assign rsp_keep_s  = imem_rsp_valid && !redirect_ok_s && (drop_cnt_r == '0);
   assign out_fire_s  = !of_empty_s && out_ready;

   assign outstanding_next_s = outstanding_r + CW'(req_fire_s) - CW'(imem_rsp_valid);

   // Next-state logic for the BOOT/FETCH/HALT sequencer.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         BOOT: begin
            if (fault_hit_s) state_next_s = HALT;
            else             state_next_s = FETCH;
         end
         FETCH: begin
            if (fault_hit_s) state_next_s = HALT;
            else             state_next_s = FETCH;
         end
         HALT:    state_next_s = HALT;
         default: state_next_s = BOOT;
      endcase
   end

   // State, PC, request accounting and sticky fault.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= BOOT;
         pc_r          <= RESET_PC;
         outstanding_r <= '0;
         drop_cnt_r    <= '0;
         fault_r       <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         outstanding_r <= outstanding_next_s;
         if (fault_hit_s) begin
            fault_r <= 1'b1;
         end
         // Everything still outstanding after a redirect belongs to the wrong path.
         if (redirect_ok_s) begin
            pc_r       <= target_s;
            drop_cnt_r <= outstanding_next_s;
         end else begin
            if (req_fire_s) begin
               pc_r <= pc_r + PC_STEP;
            end
            if (imem_rsp_valid && (drop_cnt_r != '0)) begin
               drop_cnt_r <= drop_cnt_r - CW'(1'b1);
            end
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W)) u_pc_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_ok_s),
      .push  (req_fire_s && !redirect_ok_s),
      .wdata (pc_r),
      .pop   (rsp_keep_s),
      .rdata (pq_head_s),
      .count (pq_count_s),
      .empty (pq_empty_s),
      .full  (pq_full_s)
   );

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W + ADDR_W)) u_out_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_ok_s),
      .push  (rsp_keep_s),
      .wdata ({imem_rsp_data, pq_head_s}),
      .pop   (out_fire_s),
      .rdata (of_head_s),
      .count (of_count_s),
      .empty (of_empty_s),
      .full  (of_full_s)
   );

   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = pc_r;
   assign out_valid      = !of_empty_s;
   assign out_instr      = of_empty_s ? '0 : of_head_s[DATA_W+ADDR_W-1:ADDR_W];
   assign out_pc         = of_empty_s ? '0 : of_head_s[ADDR_W-1:0];
   assign fault          = fault_r;

   assign unused_ok_s = &{1'b0, pq_count_s, pq_empty_s, pq_full_s, of_full_s, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a program-flow model.
`timescale 1ns/1ps
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int DEPTH = 2;
`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, redirect_valid, imem_req_ready, imem_rsp_valid, out_ready;
   logic [31:0] redirect_pc, imem_rsp_data;
   logic        imem_req_valid, out_valid, fault;
   logic [31:0] imem_req_addr, out_instr, out_pc;

   fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .fault(fault)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   int rel_cyc, n_req, n_out, rsp_pct;
   bit rsp_hold, halted, hold_v, last_req_fire, last_rsp;
   logic [31:0] hold_addr, last_req_addr, exp_out_pc, exp_req_pc;
   logic [31:0] mem_q[$];

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = 32'h0;
      mem_q.delete();
      exp_out_pc = 32'h0;
      exp_req_pc = 32'h0;
      halted = 1'b0;
      hold_v = 1'b0;
      n_req = 0;
      n_out = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rel_cyc = cyc;
   endtask

   // One clock cycle: memory answers in order, then handshakes are checked against the program flow.
   task automatic cycle();
      logic req_fire, out_fire, redir, fault_redir;
      fetch_entry_t exp_e;
      if (mem_q.size() > 0 && !rsp_hold && $urandom_range(99, 0) < rsp_pct) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = instr_of(mem_q.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
      #1;
      req_fire    = imem_req_valid && imem_req_ready;
      out_fire    = out_valid && out_ready;
      redir       = redirect_valid && !halted && (!ALIGN_EN || redirect_pc[1:0] == 2'b00);
      fault_redir = redirect_valid && !halted && ALIGN_EN && redirect_pc[1:0] != 2'b00;
      if (hold_v && !redirect_valid)
         chk("req_hold", {imem_req_valid, imem_req_addr}, {1'b1, hold_addr});
      if (out_fire) begin
         exp_e.instr = instr_of(exp_out_pc);
         exp_e.pc    = exp_out_pc;
         chk("out_entry", {out_instr, out_pc}, exp_e);
         exp_out_pc += 32'd4;
         n_out++;
      end
      if (req_fire) begin
         chk("req_credit", (mem_q.size() + int'(imem_rsp_valid)) < DEPTH, 1);
         if (!redir) begin
            chk("req_addr", imem_req_addr, exp_req_pc);
            exp_req_pc += 32'd4;
         end
         mem_q.push_back(imem_req_addr);
         n_req++;
      end
      if (redir) begin
         exp_out_pc = redirect_pc & 32'hFFFF_FFFC;
         exp_req_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      if (fault_redir) halted = 1'b1;
      last_req_fire = req_fire;
      last_req_addr = imem_req_addr;
      last_rsp      = imem_rsp_valid;
      hold_v    = imem_req_valid && !imem_req_ready && !redirect_valid;
      hold_addr = imem_req_addr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int first_ov;
      bit found;
      logic [31:0] r;
      rst_n = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; out_ready = 1'b1;
      rsp_pct = 100; rsp_hold = 1'b0; halted = 1'b0; hold_v = 1'b0;

      // Reset values
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_fault", fault, 0);

      // Reset release, always-ready memory with 1-cycle latency
      do_reset();
      first_ov = -1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (first_ov < 0 && out_valid) first_ov = cyc - rel_cyc;
      end
      chk("first_out_latency", first_ov, 3);
      chk("boot_outs", n_out >= 2, 1);

      // Consumer stalled: credit limits issue to DEPTH
      out_ready = 1'b0;
      do_reset();
      repeat (8) cycle();
      chk("credit_reqs", n_req, 2);
      chk("credit_stall", imem_req_valid, 0);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      repeat (4) cycle();
      chk("credit_refill", n_req, 3);

      // Redirect with two requests outstanding
      out_ready = 1'b1;
      rsp_hold = 1'b1;
      do_reset();
      repeat (5) cycle();
      chk("two_outstanding", mem_q.size(), 2);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
      cycle();
      redirect_valid = 1'b0; rsp_hold = 1'b0;
      n_out = 0;
      repeat (10) cycle();
      chk("redirect_outs", n_out > 0, 1);

      // Redirect, request handshake and response in one cycle with one outstanding
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         if (imem_req_valid && mem_q.size() == 1) found = 1'b1;
         else cycle();
      end
      chk("same_cycle_setup", found, 1);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
      cycle();
      redirect_valid = 1'b0;
      chk("same_cycle_events", {last_req_fire, last_rsp}, 2'b11);
      n_out = 0;
      repeat (8) cycle();
      chk("same_cycle_outs", n_out > 0, 1);

      // Asynchronous reset mid-burst
      do_reset();
      repeat (5) cycle();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_req_valid", imem_req_valid, 0);
      chk("async_out_valid", out_valid, 0);
      chk("async_out_instr", out_instr, 0);
      chk("async_out_pc", out_pc, 0);
      chk("async_fault", fault, 0);
      do_reset();
      repeat (4) cycle();
      chk("post_reset_reqs", n_req > 0, 1);

      // Misaligned redirect target
`ifdef FETCH_ALIGN_CHECK_EN
      out_ready = 1'b0;
      do_reset();
      repeat (6) cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
      cycle();
      redirect_valid = 1'b0;
      chk("align_fault", fault, 1);
      repeat (4) cycle();
      chk("halt_no_req", imem_req_valid, 0);
      out_ready = 1'b1;
      n_out = 0;
      repeat (4) cycle();
      chk("halt_drain", n_out, 2);
      chk("halt_empty", out_valid, 0);
      chk("halt_still_no_req", imem_req_valid, 0);
      chk("halt_fault_sticky", fault, 1);
`else
      out_ready = 1'b1;
      do_reset();
      repeat (4) cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
      cycle();
      redirect_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         cycle();
         if (last_req_fire) begin
            found = 1'b1;
            chk("unaligned_target", last_req_addr, 32'h0000_0100);
         end
      end
      chk("unaligned_req_seen", found, 1);
      chk("no_fault", fault, 0);
`endif

      // Randomized traffic against the program-flow model
      do_reset();
      rsp_pct = 60;
      for (int i = 0; i < 3000; i++) begin
         imem_req_ready = ($urandom_range(99, 0) < 75);
         out_ready      = ($urandom_range(99, 0) < 70);
         redirect_valid = ($urandom_range(19, 0) == 0);
         r = $urandom();
         if ($urandom_range(3, 0) == 0) r = 32'hFFFF_FFF0 | (r & 32'h0000_0003);
         redirect_pc = ALIGN_EN ? (r & 32'hFFFF_FFFC) : r;
         cycle();
      end
      redirect_valid = 1'b0;
      chk("random_outs", n_out > 100, 1);
      chk("random_no_fault", fault, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
